alu_issue_stage: RTL and testbench

Sequential front/back end for the team's combinational 2-bit ALU (opcodes ADD/SUB/AND/OR/XOR).
- Front end: buffers incoming {opcode, operand1, operand2} commands in a small FIFO and drives the FIFO head onto the ALU inputs.
- Back end: captures the ALU result into a registered output with valid/ready handshake.
- Decouples the command producer from the result consumer and absorbs back-pressure.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_cmd_fifo.sv | 75 +++++++
 rtl/alu_issue_stage.sv | 112 +++++++++++
 tb/tb_alu_issue_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and the packed command format of the 2-bit ALU.
package alu_pkg;

  localparam int DATA_W = 2;
  localparam int OPC_W  = 3;

  localparam logic [OPC_W-1:0] OP_ADD       = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB       = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND       = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR        = 3'b011;
  localparam logic [OPC_W-1:0] OP_XOR       = 3'b100;
  localparam logic [OPC_W-1:0] OP_MAX_LEGAL = 3'b100;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and synchronous flush.
module alu_cmd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Guard against over/underflow even if the caller misbehaves.
  assign do_push = push & (count_q != FULL_CNT);
  assign do_pop  = pop & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around the combinational ALU: command FIFO in front, registered result behind.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OPC_W  = alu_pkg::OPC_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPC_W-1:0]       in_opcode,
  input  logic [DATA_W-1:0]      in_operand1,
  input  logic [DATA_W-1:0]      in_operand2,
  output logic [OPC_W-1:0]       alu_opcode,
  output logic [DATA_W-1:0]      alu_operand1,
  output logic [DATA_W-1:0]      alu_operand2,
  input  logic [DATA_W-1:0]      alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_result,
  output logic [OPC_W-1:0]       out_opcode,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  alu_cmd_t         wr_cmd, head_cmd;
  logic [CW-1:0]    fifo_count;
  logic             push, pop, not_empty;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [OPC_W-1:0]  out_opcode_q, out_opcode_d;
  logic              out_illegal_q, out_illegal_d;

  assign wr_cmd    = '{opcode: in_opcode, operand1: in_operand1, operand2: in_operand2};
  assign not_empty = (fifo_count != '0);
  assign in_ready  = (fifo_count != FULL_CNT);
  assign push      = in_valid & in_ready;
  assign pop       = not_empty & (~out_valid_q | out_ready);

  alu_cmd_fifo #(
    .WIDTH ($bits(alu_cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head_cmd),
    .count (fifo_count)
  );

  always_comb begin
    alu_opcode   = '0;
    alu_operand1 = '0;
    alu_operand2 = '0;
    if (not_empty) begin
      alu_opcode   = head_cmd.opcode;
      alu_operand1 = head_cmd.operand1;
      alu_operand2 = head_cmd.operand2;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_opcode_d  = out_opcode_q;
    out_illegal_d = out_illegal_q;
    if (flush) begin
      out_valid_d   = 1'b0;
      out_result_d  = '0;
      out_opcode_d  = '0;
      out_illegal_d = 1'b0;
    end else if (pop) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_result;
      out_opcode_d  = head_cmd.opcode;
      out_illegal_d = (head_cmd.opcode > OP_MAX_LEGAL);
    end else if (out_valid_q && out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_opcode_q  <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_opcode_q  <= out_opcode_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_opcode  = out_opcode_q;
  assign out_illegal = out_illegal_q;
  assign count       = fifo_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_opcode = '0;
  logic [1:0] in_operand1 = '0;
  logic [1:0] in_operand2 = '0;
  logic [2:0] alu_opcode;
  logic [1:0] alu_operand1;
  logic [1:0] alu_operand2;
  logic [1:0] alu_result;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_result;
  logic [2:0] out_opcode;
  logic       out_illegal;
  logic [2:0] count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(2), .OPC_W(3), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_operand1  (in_operand1),
    .in_operand2  (in_operand2),
    .alu_opcode   (alu_opcode),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_result   (alu_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_opcode   (out_opcode),
    .out_illegal  (out_illegal),
    .count        (count)
  );

  // Stand-in for the parent's combinational ALU.
  always_comb begin
    case (alu_opcode)
      OP_ADD:  alu_result = alu_operand1 + alu_operand2;
      OP_SUB:  alu_result = alu_operand1 - alu_operand2;
      OP_AND:  alu_result = alu_operand1 & alu_operand2;
      OP_OR:   alu_result = alu_operand1 | alu_operand2;
      OP_XOR:  alu_result = alu_operand1 ^ alu_operand2;
      default: alu_result = 2'b00;
    endcase
  end

  function automatic int alu_ref(int opc, int a, int b);
    case (opc)
      0:       return (a + b) % 4;
      1:       return (a - b + 4) % 4;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int opc;
    int a;
    int b;
  } cmd_t;

  cmd_t mq[$];
  bit   m_valid, m_ill, m_live;
  int   m_res, m_opc;

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      mq.delete();
      m_valid = 0; m_res = 0; m_opc = 0; m_ill = 0;
      if (!rst_n) m_live = 1;
    end else if (m_live) begin
      bit   do_pop, do_push;
      cmd_t c, h;
      do_pop  = (mq.size() > 0) && (!m_valid || out_ready);
      do_push = in_valid && (mq.size() < DEPTH);
      c.opc = in_opcode; c.a = in_operand1; c.b = in_operand2;
      if (do_pop) begin
        h = mq.pop_front();
        m_res = alu_ref(h.opc, h.a, h.b);
        m_opc = h.opc;
        m_ill = (h.opc > 4);
        m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (do_push) mq.push_back(c);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("count", count, mq.size());
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("out_valid", out_valid, m_valid);
      chk("out_result", out_result, m_res);
      chk("out_opcode", out_opcode, m_opc);
      chk("out_illegal", out_illegal, m_ill);
      chk("alu_opcode", alu_opcode, mq.size() > 0 ? mq[0].opc : 0);
      chk("alu_operand1", alu_operand1, mq.size() > 0 ? mq[0].a : 0);
      chk("alu_operand2", alu_operand2, mq.size() > 0 ? mq[0].b : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int opc, int a, int b);
    in_valid    = 1'b1;
    in_opcode   = 3'(opc);
    in_operand1 = 2'(a);
    in_operand2 = 2'(b);
  endtask

  // Starts just after an edge; pushes one command, then checks the registered result.
  task automatic single(string tag, int opc, int a, int b, int exp_res, int exp_ill);
    out_ready = 1'b1;
    drive(opc, a, b);
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, out_result, exp_res);
    chk({tag, "_opcode"}, out_opcode, opc);
    chk({tag, "_illegal"}, out_illegal, exp_ill);
    step();
    step();
  endtask

  // Leaves count=3 with out_valid=1, then applies reset or flush for one edge.
  task automatic clear_mid_op(bit use_flush);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i, i % 4, 3 - (i % 4));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("preclear_count", count, 3);
    chk("preclear_valid", out_valid, 1);
    step();
    if (use_flush) flush = 1'b1; else rst_n = 1'b0;
    step();
    flush = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("clear_count", count, 0);
    chk("clear_valid", out_valid, 0);
    chk("clear_ready", in_ready, 1);
    chk("clear_alu_opc", alu_opcode, 0);
    chk("clear_alu_op1", alu_operand1, 0);
    step();
    single("postclear_add", 0, 1, 1, 2, 0);
  endtask

  initial begin
    int exp_bp[5];
    exp_bp = '{3, 2, 2, 3, 0};

    step();
    step();
    @(negedge clk);
    chk("reset_count", count, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_result", out_result, 0);
    step();
    rst_n = 1'b1;
    step();

    single("add", 0, 1, 1, 2, 0);
    single("sub_wrap", 1, 0, 1, 3, 0);
    single("xor", 4, 3, 2, 1, 0);
    single("illegal", 7, 3, 3, 0, 1);

    // Back-pressure: five commands with the consumer stalled.
    out_ready = 1'b0;
    drive(0, 1, 2); step();
    drive(1, 3, 1); step();
    drive(2, 3, 2); step();
    drive(3, 1, 2); step();
    drive(4, 3, 3); step();
    drive(0, 2, 2);
    @(negedge clk);
    chk("bp_count_full", count, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_first_result", out_result, 3);
    step();
    step();
    @(negedge clk);
    chk("bp_count_held", count, 4);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_result", out_result, exp_bp[k]);
      step();
    end
    step();

    // Steady push/pop at count=2.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
      @(negedge clk);
      chk("steady_count", count, 2);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    clear_mid_op(1'b0);
    clear_mid_op(1'b1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_opcode   = 3'($urandom_range(0, 7));
      in_operand1 = 2'($urandom_range(0, 3));
      in_operand2 = 2'($urandom_range(0, 3));
      out_ready   = ($urandom_range(0, 9) < 5);
      flush       = ($urandom_range(0, 59) == 0);
      rst_n       = ($urandom_range(0, 149) != 0);
      step();
    end
    flush = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
